kernel_sequencer: RTL and testbench
===================================

Name: kernel_sequencer

Overview:
- Synthesisable, cycle-accurate instruction sequencer for the TIA core. It replaces the behavioural 6502 stand-in used for frame generation.
- Fetches a restricted 6502 opcode stream from a synchronous ROM and executes LDA/LDX/LDY imm, STA/STX/STY zp, NOP and JMP with real 6502 cycle counts.
- Drives the TIA d/a/rw bus and stalls on rdy after WSYNC. Emits a trace strobe per retired instruction.
- Generalised in ROM size, bank alignment, WSYNC address and counter width; adds error and done reporting.

Parameters:
ADDR_W, 14, ROM address width (2^ADDR_W bytes max).
JMP_ALIGN, 10, JMP target = next 2^JMP_ALIGN-byte bank boundary.
WSYNC_ADDR, 6'h02, store address that triggers the rdy stall.
CNT_W, 20, width of the CPU-cycle counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clock strobe per CPU cycle (phi_theta rising); ticks are >=2 clocks apart
start  in  1  pulse: begin execution at pc=0 (ignored unless idle)
rom_size  in  ADDR_W+1  number of valid ROM bytes
rom_addr  out  ADDR_W  ROM read address (= pc)
rom_data  in  8  ROM byte, valid one clock after rom_addr
rdy  in  1  TIA rdy; 0 = halt CPU
tia_a  out  6  TIA register address
tia_d  out  8  TIA write data
tia_rw  out  1  0 = write, 1 = read/idle
busy  out  1  executing (FETCH through WSYNC)
done  out  1  sticky: pc reached rom_size
error  out  1  sticky: unsupported opcode
cycle_count  out  CNT_W  ticks since start; saturates at all-ones
trace_valid  out  1  one-clock pulse per retired instruction
trace_pc  out  ADDR_W  opcode address of retired instruction
trace_op  out  8  opcode of retired instruction

Behaviour:
- Reset values:
  - state IDLE; pc=0; A=X=Y=0.
  - tia_a=6'h3F, tia_d=0, tia_rw=1.
  - busy=done=error=trace_valid=0; cycle_count=0; trace_pc=0; trace_op=0.
- All state changes occur only on clocks with tick=1, except the trace_valid deassert and start detection.
- States:
  - IDLE: on start, go to FETCH. pc=0, cycle_count=0, done=error=0.
  - FETCH (tick):
    - Latch op=rom_data and op_pc=pc; pc+=1.
    - A9/A2/A0/EA go to EXECUTE; 85/86/84/4C go to OPWAIT.
    - Any other opcode goes to ERROR.
  - OPWAIT (tick): go to EXECUTE. Gives 3-cycle ST*/JMP.
  - EXECUTE (tick):
    - LD*: reg <= rom_data; pc+=1.
    - NOP: no operand.
    - ST*: tia_a <= rom_data[5:0], tia_d <= reg, tia_rw <= 0; pc+=1.
    - JMP: pc <= ((op_pc+1) + 2^JMP_ALIGN - 1) with the low JMP_ALIGN bits cleared.
    - Pulse trace_valid.
    - Next state: WSYNC if a store was made to WSYNC_ADDR. Otherwise DONE if pc_next >= rom_size, else FETCH.
  - WSYNC (tick):
    - rdy==0: remain.
    - rdy==1: perform the FETCH action on this same tick.
  - DONE: done=1, busy=0; return to IDLE-equivalent (a new start is accepted).
  - ERROR: error=1, busy=0; hold until reset.
- tia_rw:
  - Low for exactly one tick period, from the EXECUTE tick of ST* to the next tick; high otherwise.
  - tia_a and tia_d hold their last values.
- cycle_count increments on every tick while busy, including WSYNC stall ticks.
- Latency:
  - LD*/NOP retire 2 ticks after the fetch tick begins.
  - ST*/JMP retire after 3 ticks.
  - WSYNC adds one tick per rdy=0 tick.
- Boundaries:
  - JMP from the last byte of a bank goes to the next bank.
  - pc wrap at 2^ADDR_W counts as >= rom_size, so the sequencer ends in DONE.
  - rom_size=0 on start goes directly to DONE.
  - Asynchronous reset mid-instruction aborts with no further bus write.

Decomposition:
- Package tia_seq_pkg: opcode constants (JMP 4C, LDA A9, LDX A2, LDY A0, NOP EA, STA 85, STX 86, STY 84), state encoding, opcode-class function (imm2/zp3/jmp3/illegal).
- No sub-module; a single FSM plus datapath.

Test Plan:
- ROM {A9 1E, 85 09, EA}, rom_size=5, rdy=1 → the bench checks:
  - trace pcs 0, 2, 4.
  - tia_rw low one tick with tia_a=09, tia_d=1E.
  - done after cycle_count=7.
- ROM {A2 55, 86 02, A0 07}, rdy held 0 for 10 ticks after the STX → the bench checks:
  - LDY fetch is delayed by exactly 10 ticks.
  - cycle_count at done = 17.
- JMP_ALIGN=10, JMP at 0x003 and LDA 42 at 0x400, rom_size=0x402 → the bench checks:
  - next trace_pc=0x400.
  - A=42.
  - JMP at 0x3FF also targets 0x400.
- Opcode 0xFF at pc=2 → the bench checks:
  - error=1, busy=0.
  - no tia_rw low pulse afterwards.
  - start is ignored until reset.
- Reset asserted on the OPWAIT tick of STA → the bench checks:
  - outputs immediately at reset values (tia_rw=1, tia_a=3F).
  - a new start re-executes from pc=0.
- start while busy is ignored → the bench checks that trace sequence and cycle_count are unchanged.

Source files
------------

// File: rtl/tia_seq_pkg.sv
// -----------------------------------------------------------------------------
// tia_seq_pkg
// Shared definitions for the kernel sequencer: the 6502 opcodes it understands,
// the FSM state encoding and a helper that sorts an opcode into its timing class.
// -----------------------------------------------------------------------------
package tia_seq_pkg;

    localparam logic [7:0] OP_JMP = 8'h4C;
    localparam logic [7:0] OP_LDA = 8'hA9;
    localparam logic [7:0] OP_LDX = 8'hA2;
    localparam logic [7:0] OP_LDY = 8'hA0;
    localparam logic [7:0] OP_NOP = 8'hEA;
    localparam logic [7:0] OP_STA = 8'h85;
    localparam logic [7:0] OP_STX = 8'h86;
    localparam logic [7:0] OP_STY = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OPWAIT,
        ST_EXECUTE,
        ST_WSYNC,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    // imm2: two-cycle ops (immediate loads and NOP); zp3: zero-page stores;
    // jmp3: absolute jump; illegal: anything the sequencer cannot run.
    typedef enum logic [1:0] {
        CLS_IMM2,
        CLS_ZP3,
        CLS_JMP3,
        CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input logic [7:0] op);
        op_class_e cls;
        case (op)
            OP_LDA, OP_LDX, OP_LDY, OP_NOP: cls = CLS_IMM2;
            OP_STA, OP_STX, OP_STY:         cls = CLS_ZP3;
            OP_JMP:                         cls = CLS_JMP3;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/kernel_sequencer_if.sv
// -----------------------------------------------------------------------------
// kernel_sequencer_if
// Bus bundle between the sequencer and its surroundings.
//   rom_addr/rom_data : synchronous ROM read port (data one clock after address)
//   rdy               : TIA ready, 0 holds the CPU
//   tia_a/tia_d/tia_rw: TIA register write bus (rw=0 is a write)
//   trace_*           : one-clock retire strobe with opcode address and opcode
// master = sequencer side, slave = ROM/TIA/trace consumer side.
// -----------------------------------------------------------------------------
interface kernel_sequencer_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rdy;
    logic [5:0]        tia_a;
    logic [7:0]        tia_d;
    logic              tia_rw;
    logic              trace_valid;
    logic [ADDR_W-1:0] trace_pc;
    logic [7:0]        trace_op;

    modport master (
        output rom_addr, tia_a, tia_d, tia_rw, trace_valid, trace_pc, trace_op,
        input  rom_data, rdy
    );

    modport slave (
        input  rom_addr, tia_a, tia_d, tia_rw, trace_valid, trace_pc, trace_op,
        output rom_data, rdy
    );
endinterface

// File: rtl/kernel_sequencer.sv
// -----------------------------------------------------------------------------
// kernel_sequencer
// Cycle-accurate 6502 subset sequencer driving the TIA bus. Executes
// LDA/LDX/LDY #imm, STA/STX/STY zp, NOP and JMP with real cycle counts, one
// CPU cycle per tick, and stalls after a store to WSYNC until rdy returns.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   tick              : one-clock strobe per CPU cycle
//   start             : begin at pc=0 (only from idle/done)
//   rom_size          : number of valid ROM bytes
//   bus               : ROM port, TIA bus, rdy and trace (master side)
//   busy/done/error   : status; done and error are sticky
//   cycle_count       : ticks spent busy since start, saturating
// -----------------------------------------------------------------------------
module kernel_sequencer
    import tia_seq_pkg::*;
#(
    parameter int         ADDR_W     = 14,
    parameter int         JMP_ALIGN  = 10,
    parameter logic [5:0] WSYNC_ADDR = 6'h02,
    parameter int         CNT_W      = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic [ADDR_W:0]     rom_size,
    kernel_sequencer_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [ADDR_W:0]   ALIGN_MASK = (ADDR_W+1)'((1 << JMP_ALIGN) - 1);
    localparam logic [ADDR_W:0]   PC_EXT_ONE = 1;
    localparam logic [ADDR_W-1:0] PC_ONE     = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wrap_q, wrap_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic [7:0]        a_q, a_d, x_q, x_d, y_q, y_d;
    logic [5:0]        tia_a_q, tia_a_d;
    logic [7:0]        tia_d_q, tia_d_d;
    logic              tia_rw_q, tia_rw_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trace_valid_q, trace_valid_d;
    logic [ADDR_W-1:0] trace_pc_q, trace_pc_d;
    logic [7:0]        trace_op_q, trace_op_d;

    op_class_e         exec_class;
    seq_state_e        fetch_state;
    logic              is_store, wsync_hit, finished, fetch_tick, state_busy;
    logic [ADDR_W:0]   pc_ext, pc_next_ext;
    logic [7:0]        store_data;

    // State register and all datapath flops; reset puts the TIA bus idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            wrap_q        <= 1'b0;
            op_q          <= '0;
            op_pc_q       <= '0;
            a_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            tia_a_q       <= 6'h3F;
            tia_d_q       <= '0;
            tia_rw_q      <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cnt_q         <= '0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_op_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wrap_q        <= wrap_d;
            op_q          <= op_d;
            op_pc_q       <= op_pc_d;
            a_q           <= a_d;
            x_q           <= x_d;
            y_q           <= y_d;
            tia_a_q       <= tia_a_d;
            tia_d_q       <= tia_d_d;
            tia_rw_q      <= tia_rw_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cnt_q         <= cnt_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_op_q    <= trace_op_d;
        end
    end

    // Decode of the latched opcode and the incoming ROM byte. The pc is
    // widened by one bit so that running off the top of the address space
    // still compares as past the end of the ROM.
    always_comb begin
        exec_class = op_class(op_q);
        is_store   = (exec_class == CLS_ZP3);
        wsync_hit  = is_store && (bus.rom_data[5:0] == WSYNC_ADDR);
        pc_ext     = {1'b0, pc_q};
        if (exec_class == CLS_JMP3) begin
            pc_next_ext = (pc_ext + ALIGN_MASK) & ~ALIGN_MASK;
        end else if (op_q == OP_NOP) begin
            pc_next_ext = pc_ext;
        end else begin
            pc_next_ext = pc_ext + PC_EXT_ONE;
        end
        finished = wrap_q || pc_next_ext[ADDR_W] || (pc_next_ext >= rom_size);
        case (op_q)
            OP_STX:  store_data = x_q;
            OP_STY:  store_data = y_q;
            default: store_data = a_q;
        endcase
        case (op_class(bus.rom_data))
            CLS_IMM2:          fetch_state = ST_EXECUTE;
            CLS_ZP3, CLS_JMP3: fetch_state = ST_OPWAIT;
            default:           fetch_state = ST_ERROR;
        endcase
        state_busy = (state_q == ST_FETCH) || (state_q == ST_OPWAIT) ||
                     (state_q == ST_EXECUTE) || (state_q == ST_WSYNC);
        fetch_tick = tick && ((state_q == ST_FETCH) ||
                              ((state_q == ST_WSYNC) && bus.rdy));
    end

    // Next-state logic. Only start is honoured between ticks; a WSYNC
    // release behaves exactly like a fetch on the same tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (rom_size == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (tick) begin
                    state_d = fetch_state;
                end
            end
            ST_OPWAIT: begin
                if (tick) begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (tick) begin
                    if (wsync_hit) begin
                        state_d = ST_WSYNC;
                    end else if (finished) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WSYNC: begin
                if (fetch_tick) begin
                    state_d = fetch_state;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Datapath and output updates. tia_rw returns high on the tick after a
    // store; trace_valid is a single-clock pulse regardless of tick.
    always_comb begin
        pc_d          = pc_q;
        wrap_d        = wrap_q;
        op_d          = op_q;
        op_pc_d       = op_pc_q;
        a_d           = a_q;
        x_d           = x_q;
        y_d           = y_q;
        tia_a_d       = tia_a_q;
        tia_d_d       = tia_d_q;
        tia_rw_d      = tick ? 1'b1 : tia_rw_q;
        done_d        = done_q;
        error_d       = error_q;
        cnt_d         = cnt_q;
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_op_d    = trace_op_q;

        if (tick && state_busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            pc_d    = '0;
            wrap_d  = 1'b0;
            cnt_d   = '0;
            error_d = 1'b0;
            done_d  = (rom_size == '0);
        end

        if (fetch_tick) begin
            op_d    = bus.rom_data;
            op_pc_d = pc_q;
            pc_d    = pc_q + PC_ONE;
            wrap_d  = (pc_q == '1);
            if (fetch_state == ST_ERROR) begin
                error_d = 1'b1;
            end
        end

        if ((state_q == ST_EXECUTE) && tick) begin
            case (op_q)
                OP_LDA:  a_d = bus.rom_data;
                OP_LDX:  x_d = bus.rom_data;
                OP_LDY:  y_d = bus.rom_data;
                default: ;
            endcase
            if (is_store) begin
                tia_a_d  = bus.rom_data[5:0];
                tia_d_d  = store_data;
                tia_rw_d = 1'b0;
            end
            pc_d          = pc_next_ext[ADDR_W-1:0];
            trace_valid_d = 1'b1;
            trace_pc_d    = op_pc_q;
            trace_op_d    = op_q;
            if (!wsync_hit && finished) begin
                done_d = 1'b1;
            end
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.tia_a       = tia_a_q;
    assign bus.tia_d       = tia_d_q;
    assign bus.tia_rw      = tia_rw_q;
    assign bus.trace_valid = trace_valid_q;
    assign bus.trace_pc    = trace_pc_q;
    assign bus.trace_op    = trace_op_q;
    assign busy            = state_busy;
    assign done            = done_q;
    assign error           = error_q;
    assign cycle_count     = cnt_q;

endmodule

// File: tb/tb_kernel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kernel_sequencer
// Directed bench for kernel_sequencer: small ROM programs with hand-worked
// trace addresses, bus writes and cycle counts.
// -----------------------------------------------------------------------------
module tb_kernel_sequencer;

    logic        clock;
    logic        reset;
    logic        tick;
    logic        start;
    logic [14:0] romSize;
    logic        busy;
    logic        done;
    logic        error;
    logic [19:0] cycleCount;

    logic [7:0]  rom [0:16383];

    int          checksDone   = 0;
    int          checksPassed = 0;
    int          tickCount    = 0;
    int          writeCount   = 0;
    int          fallTick     = 0;
    int          rwLowTicks   = 0;
    logic        prevRw       = 1'b1;
    logic [5:0]  lastA        = '0;
    logic [7:0]  lastD        = '0;
    logic [13:0] traceQ [$];
    logic [7:0]  traceOpQ [$];
    int          traceTickQ [$];
    int          traceBase;
    int          writeBase;
    int          guard;

    kernel_sequencer_if #(.ADDR_W(14)) bus ();

    kernel_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .rom_size    (romSize),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cycle_count (cycleCount)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // CPU cycle strobe: one clock high out of every four.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
        end
    end

    // Synchronous ROM model, data one clock after address.
    always @(posedge clock) begin
        bus.rom_data <= rom[bus.rom_addr];
    end

    // Tick counter used as the time base for latency checks.
    always @(posedge clock) begin
        if (tick) tickCount <= tickCount + 1;
    end

    // Bus monitor: records retired instructions and TIA write pulses.
    always @(negedge clock) begin
        if (bus.trace_valid) begin
            traceQ.push_back(bus.trace_pc);
            traceOpQ.push_back(bus.trace_op);
            traceTickQ.push_back(tickCount);
        end
        if (!bus.tia_rw && prevRw) begin
            writeCount <= writeCount + 1;
            lastA      <= bus.tia_a;
            lastD      <= bus.tia_d;
            fallTick   <= tickCount;
        end
        if (bus.tia_rw && !prevRw) begin
            rwLowTicks <= tickCount - fallTick;
        end
        prevRw <= bus.tia_rw;
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksDone++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse start one clock after a tick so the ROM has refreshed by the fetch.
    task automatic applyStimulus(input logic [14:0] size);
        romSize = size;
        @(posedge clock);
        while (!tick) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxClocks);
        int n;
        n = 0;
        while (!done && n < maxClocks) begin
            @(negedge clock);
            n++;
        end
        checkOutput("doneReached", {31'd0, done}, 32'd1);
        @(negedge clock);
    endtask

    task automatic loadSimple();
        rom[0] = 8'hA9; rom[1] = 8'h1E; rom[2] = 8'h85; rom[3] = 8'h09; rom[4] = 8'hEA;
    endtask

    task automatic markRun();
        traceBase = traceQ.size();
        writeBase = writeCount;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        romSize = '0;
        bus.rdy = 1'b1;
        for (int i = 0; i < 16384; i++) rom[i] = 8'hFF;
        repeat (5) @(negedge clock);

        $display("[TB] reset values");
        checkOutput("rstRw",     {31'd0, bus.tia_rw}, 32'd1);
        checkOutput("rstA",      {26'd0, bus.tia_a}, 32'h3F);
        checkOutput("rstD",      {24'd0, bus.tia_d}, 32'h00);
        checkOutput("rstBusy",   {31'd0, busy}, 32'd0);
        checkOutput("rstDone",   {31'd0, done}, 32'd0);
        checkOutput("rstError",  {31'd0, error}, 32'd0);
        checkOutput("rstCount",  {12'd0, cycleCount}, 32'd0);
        checkOutput("rstTrace",  {31'd0, bus.trace_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] LDA/STA/NOP program");
        loadSimple();
        markRun();
        applyStimulus(15'd5);
        checkOutput("s1Busy", {31'd0, busy}, 32'd1);
        waitDone(400);
        checkOutput("s1Traces", traceQ.size() - traceBase, 3);
        checkOutput("s1Pc0", {18'd0, traceQ[traceBase]}, 32'h0);
        checkOutput("s1Pc1", {18'd0, traceQ[traceBase+1]}, 32'h2);
        checkOutput("s1Pc2", {18'd0, traceQ[traceBase+2]}, 32'h4);
        checkOutput("s1Op1", {24'd0, traceOpQ[traceBase+1]}, 32'h85);
        checkOutput("s1Writes", writeCount - writeBase, 1);
        checkOutput("s1A", {26'd0, lastA}, 32'h09);
        checkOutput("s1D", {24'd0, lastD}, 32'h1E);
        checkOutput("s1RwLow", rwLowTicks, 1);
        checkOutput("s1Count", {12'd0, cycleCount}, 32'd7);
        checkOutput("s1BusyEnd", {31'd0, busy}, 32'd0);

        $display("[TB] start while busy");
        markRun();
        applyStimulus(15'd5);
        repeat (10) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(400);
        checkOutput("s6Traces", traceQ.size() - traceBase, 3);
        checkOutput("s6Pc1", {18'd0, traceQ[traceBase+1]}, 32'h2);
        checkOutput("s6Pc2", {18'd0, traceQ[traceBase+2]}, 32'h4);
        checkOutput("s6Count", {12'd0, cycleCount}, 32'd7);

        $display("[TB] WSYNC stall");
        rom[0] = 8'hA2; rom[1] = 8'h55; rom[2] = 8'h86; rom[3] = 8'h02;
        rom[4] = 8'hA0; rom[5] = 8'h07;
        markRun();
        applyStimulus(15'd6);
        guard = 0;
        while ((traceQ.size() - traceBase) < 2 && guard < 400) begin
            @(posedge clock);
            guard++;
        end
        checkOutput("s2StxRetired", traceQ.size() - traceBase, 2);
        @(negedge clock);
        bus.rdy = 1'b0;
        repeat (10) begin
            @(posedge clock);
            while (!tick) @(posedge clock);
        end
        @(negedge clock);
        checkOutput("s2BusyStall", {31'd0, busy}, 32'd1);
        bus.rdy = 1'b1;
        waitDone(400);
        checkOutput("s2Traces", traceQ.size() - traceBase, 3);
        checkOutput("s2Pc2", {18'd0, traceQ[traceBase+2]}, 32'h4);
        checkOutput("s2Delay", traceTickQ[traceBase+2] - traceTickQ[traceBase+1], 12);
        checkOutput("s2A", {26'd0, lastA}, 32'h02);
        checkOutput("s2D", {24'd0, lastD}, 32'h55);
        checkOutput("s2Count", {12'd0, cycleCount}, 32'd17);

        $display("[TB] JMP from 0x003");
        for (int i = 0; i < 16'h404; i++) rom[i] = 8'hEA;
        rom[16'h003] = 8'h4C;
        rom[16'h400] = 8'hA9; rom[16'h401] = 8'h42;
        rom[16'h402] = 8'h85; rom[16'h403] = 8'h10;
        markRun();
        applyStimulus(15'h404);
        waitDone(2000);
        checkOutput("s3Traces", traceQ.size() - traceBase, 6);
        checkOutput("s3JmpPc", {18'd0, traceQ[traceBase+3]}, 32'h003);
        checkOutput("s3Target", {18'd0, traceQ[traceBase+4]}, 32'h400);
        checkOutput("s3RegA", {24'd0, lastD}, 32'h42);
        checkOutput("s3Addr", {26'd0, lastA}, 32'h10);
        checkOutput("s3Count", {12'd0, cycleCount}, 32'd14);

        $display("[TB] JMP from last byte of bank");
        for (int i = 0; i < 16'h3FF; i++) rom[i] = 8'hEA;
        rom[16'h3FF] = 8'h4C;
        markRun();
        applyStimulus(15'h402);
        waitDone(20000);
        checkOutput("s3bTraces", traceQ.size() - traceBase, 1025);
        checkOutput("s3bJmpPc", {18'd0, traceQ[traceBase+1023]}, 32'h3FF);
        checkOutput("s3bTarget", {18'd0, traceQ[traceBase+1024]}, 32'h400);
        checkOutput("s3bCount", {12'd0, cycleCount}, 32'd2051);

        $display("[TB] empty ROM");
        markRun();
        applyStimulus(15'd0);
        @(negedge clock);
        checkOutput("s0Done", {31'd0, done}, 32'd1);
        checkOutput("s0Busy", {31'd0, busy}, 32'd0);
        checkOutput("s0Count", {12'd0, cycleCount}, 32'd0);
        repeat (20) @(negedge clock);
        checkOutput("s0Traces", traceQ.size() - traceBase, 0);

        $display("[TB] reset during STA");
        loadSimple();
        markRun();
        applyStimulus(15'd5);
        guard = 0;
        while ((traceQ.size() - traceBase) < 1 && guard < 400) begin
            @(posedge clock);
            guard++;
        end
        checkOutput("s5LdaRetired", traceQ.size() - traceBase, 1);
        @(posedge clock);
        while (!tick) @(posedge clock);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("s5Rw", {31'd0, bus.tia_rw}, 32'd1);
        checkOutput("s5A", {26'd0, bus.tia_a}, 32'h3F);
        checkOutput("s5D", {24'd0, bus.tia_d}, 32'h00);
        checkOutput("s5Busy", {31'd0, busy}, 32'd0);
        checkOutput("s5Count", {12'd0, cycleCount}, 32'd0);
        repeat (8) @(negedge clock);
        checkOutput("s5NoWrite", writeCount - writeBase, 0);
        reset = 1'b0;
        @(negedge clock);
        markRun();
        applyStimulus(15'd5);
        waitDone(400);
        checkOutput("s5Traces", traceQ.size() - traceBase, 3);
        checkOutput("s5Pc0", {18'd0, traceQ[traceBase]}, 32'h0);
        checkOutput("s5Writes", writeCount - writeBase, 1);
        checkOutput("s5WriteD", {24'd0, lastD}, 32'h1E);
        checkOutput("s5Count2", {12'd0, cycleCount}, 32'd7);

        $display("[TB] illegal opcode");
        rom[0] = 8'hA9; rom[1] = 8'h11; rom[2] = 8'hFF; rom[3] = 8'h85; rom[4] = 8'h09;
        markRun();
        applyStimulus(15'd10);
        guard = 0;
        while (!error && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("s4Error", {31'd0, error}, 32'd1);
        checkOutput("s4Busy", {31'd0, busy}, 32'd0);
        checkOutput("s4Done", {31'd0, done}, 32'd0);
        checkOutput("s4Count", {12'd0, cycleCount}, 32'd3);
        repeat (40) @(negedge clock);
        checkOutput("s4NoWrite", writeCount - writeBase, 0);
        checkOutput("s4Traces", traceQ.size() - traceBase, 1);
        applyStimulus(15'd10);
        repeat (40) @(negedge clock);
        checkOutput("s4StartBusy", {31'd0, busy}, 32'd0);
        checkOutput("s4StartError", {31'd0, error}, 32'd1);
        checkOutput("s4StartCount", {12'd0, cycleCount}, 32'd3);
        checkOutput("s4StartTraces", traceQ.size() - traceBase, 1);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
